// File: rtl/epc_pkg.sv
// Shared types and MISR constants for the exhaustive pattern capture stage.
package epc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } epc_state_t;

    localparam logic [15:0] EPC_MISR_POLY = 16'h1021;
    localparam logic [15:0] EPC_MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/exhaustive_pattern_capture_if.sv
// Stimulus/capture bundle between the sweep controller and its environment.
interface exhaustive_pattern_capture_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned SIG_W = 16
);
    localparam int unsigned NPAT = 1 << N_IN;

    logic              start;
    logic [NPAT-1:0]   golden;
    logic              dut_out;
    logic [N_IN-1:0]   pattern;
    logic              pat_valid;
    logic              busy;
    logic              done;
    logic [NPAT-1:0]   resp_vec;
    logic [SIG_W-1:0]  signature;
    logic [N_IN:0]     mismatch_cnt;
    logic              trojan_flag;

    modport master (
        output start, golden, dut_out,
        input  pattern, pat_valid, busy, done, resp_vec, signature,
               mismatch_cnt, trojan_flag
    );

    modport slave (
        input  start, golden, dut_out,
        output pattern, pat_valid, busy, done, resp_vec, signature,
               mismatch_cnt, trojan_flag
    );

endinterface

// File: rtl/epc_misr.sv
// 16-bit bit-serial MISR (CRC-CCITT, MSB-first); clr reloads the seed.
module epc_misr
    import epc_pkg::*;
(
    input  logic        CK,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;
    logic        fb;

    always_comb begin
        fb    = sig_q[15] ^ din;
        sig_d = sig_q;
        if (clr) begin
            sig_d = EPC_MISR_SEED;
        end else if (en) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (fb ? EPC_MISR_POLY : 16'h0000);
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig_q <= EPC_MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/exhaustive_pattern_capture.sv
// Walks every input pattern, holds each for SETTLE cycles, captures the
// black-box response and compares it against a latched golden vector.
module exhaustive_pattern_capture
    import epc_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned SIG_W  = 16
) (
    input logic                    CK,
    input logic                    reset,
    exhaustive_pattern_capture_if.slave bus
);

    localparam int unsigned NPAT      = 1 << N_IN;
    localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);

    typedef logic [N_IN:0] cnt_t;

    epc_state_t      state_q;
    logic [N_IN-1:0] pattern_q;
    logic [7:0]      settle_q;
    logic [NPAT-1:0] resp_q;
    logic [NPAT-1:0] resp_d;
    logic [NPAT-1:0] golden_q;
    logic [NPAT-1:0] diff;
    cnt_t            mm_q;
    cnt_t            mm_d;
    logic            trojan_q;
    logic            busy_q;
    logic            pat_valid_q;
    logic            done_q;
    logic            accept;
    logic            capture;
    logic [15:0]     sig;

    assign accept  = bus.start && (state_q != APPLY);
    assign capture = (state_q == APPLY) && (settle_q == 8'd0);

    // Score against the response vector including the bit being captured now,
    // so the counts are ready on the same edge that enters DONE.
    always_comb begin
        resp_d            = resp_q;
        resp_d[pattern_q] = bus.dut_out;
        diff              = resp_d ^ golden_q;
        mm_d              = '0;
        for (int unsigned i = 0; i < NPAT; i++) begin
            mm_d = mm_d + cnt_t'(diff[i]);
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            settle_q    <= '0;
            resp_q      <= '0;
            golden_q    <= '0;
            mm_q        <= '0;
            trojan_q    <= 1'b0;
            busy_q      <= 1'b0;
            pat_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q     <= APPLY;
                        pattern_q   <= '0;
                        settle_q    <= SETTLE_M1;
                        resp_q      <= '0;
                        golden_q    <= bus.golden;
                        mm_q        <= '0;
                        trojan_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        pat_valid_q <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (settle_q != 8'd0) begin
                        settle_q <= settle_q - 8'd1;
                    end else begin
                        resp_q <= resp_d;
                        if (pattern_q != '1) begin
                            pattern_q <= pattern_q + 1'b1;
                            settle_q  <= SETTLE_M1;
                        end else begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            pat_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            mm_q        <= mm_d;
                            trojan_q    <= (mm_d != '0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    epc_misr u_misr (
        .CK    (CK),
        .reset (reset),
        .clr   (accept),
        .en    (capture),
        .din   (bus.dut_out),
        .sig   (sig)
    );

    assign bus.pattern      = pattern_q;
    assign bus.pat_valid    = pat_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.resp_vec     = resp_q;
    assign bus.signature    = SIG_W'(sig);
    assign bus.mismatch_cnt = mm_q;
    assign bus.trojan_flag  = trojan_q;

endmodule

// File: tb/tb_exhaustive_pattern_capture.sv
// Randomised self-checking bench for exhaustive_pattern_capture (SETTLE 1/2/3).
module tb_exhaustive_pattern_capture;

    logic CK = 1'b0;
    logic reset = 1'b0;
    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;
    int mode = 0;
    logic [7:0] rand_tt = 8'h00;

    exhaustive_pattern_capture_if #(.N_IN(3)) bus2 ();
    exhaustive_pattern_capture_if #(.N_IN(3)) bus1 ();
    exhaustive_pattern_capture_if #(.N_IN(3)) bus3 ();

    exhaustive_pattern_capture #(.N_IN(3), .SETTLE(2), .SIG_W(16)) u_dut2 (
        .CK(CK), .reset(reset), .bus(bus2));
    exhaustive_pattern_capture #(.N_IN(3), .SETTLE(1), .SIG_W(16)) u_dut1 (
        .CK(CK), .reset(reset), .bus(bus1));
    exhaustive_pattern_capture #(.N_IN(3), .SETTLE(3), .SIG_W(16)) u_dut3 (
        .CK(CK), .reset(reset), .bus(bus3));

    // Black-box block under test: N[0] is the pattern MSB.
    function automatic logic ref_out(input int m, input logic [2:0] pat, input logic [7:0] tt);
        logic n0, n1, n2;
        n0 = pat[2]; n1 = pat[1]; n2 = pat[0];
        case (m)
            0: return 1'b0;
            1: return 1'b1;
            2: return n0 & n1 & n2;
            3: return (n0 & n1 & n2) ^ (pat == 3'b101);
            default: return tt[pat];
        endcase
    endfunction

    always_comb bus2.dut_out = ref_out(mode, bus2.pattern, rand_tt);
    always_comb bus1.dut_out = ref_out(mode, bus1.pattern, rand_tt);
    always_comb bus3.dut_out = ref_out(mode, bus3.pattern, rand_tt);

    function automatic logic [7:0] exp_resp(input int m, input logic [7:0] tt);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = ref_out(m, 3'(k), tt);
        return r;
    endfunction

    function automatic logic [15:0] exp_sig(input logic [7:0] r);
        logic [15:0] s;
        logic fb;
        s = 16'hFFFF;
        for (int k = 0; k < 8; k++) begin
            fb = s[15] ^ r[k];
            s  = (s << 1) ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    function automatic int popcnt(input logic [7:0] x);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) n += int'(x[k]);
        return n;
    endfunction

    // Start a sweep on the SETTLE=2 instance; optionally pulse start mid-sweep.
    task automatic sweep2(input logic [7:0] gold, input int pulse_at, output int dcyc);
        @(negedge CK);
        bus2.start  = 1'b1;
        bus2.golden = gold;
        @(posedge CK);
        #1;
        bus2.start  = 1'b0;
        bus2.golden = ~gold;
        dcyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CK);
            if (c == pulse_at) bus2.start = 1'b1;
            @(posedge CK);
            #1;
            bus2.start = 1'b0;
            if (bus2.done) begin
                dcyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [34:0] obs;
        reset = 1'b0;
        bus2.start = 1'b1; bus2.golden = 8'h00;
        bus1.start = 1'b0; bus1.golden = 8'h00;
        bus3.start = 1'b0; bus3.golden = 8'h00;
        repeat (3) @(posedge CK);
        #1;
        obs = {bus2.pattern, bus2.pat_valid, bus2.busy, bus2.done, bus2.resp_vec,
               bus2.signature, bus2.mismatch_cnt, bus2.trojan_flag};
        checks++;
        if (obs !== {3'd0, 3'b000, 8'h00, 16'hFFFF, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs,
                     {3'd0, 3'b000, 8'h00, 16'hFFFF, 4'd0, 1'b0});
        end
        @(negedge CK);
        bus2.start = 1'b0;
        reset = 1'b1;
        @(posedge CK);
        #1;
        checks++;
        if (bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", bus2.busy, bus2.done);
        end
    endtask

    task automatic test_sweep_table();
        int modes[4] = '{0, 1, 2, 3};
        logic [7:0] golds[4] = '{8'h00, 8'hFF, 8'h80, 8'h80};
        int dcyc;
        logic [7:0] er;
        for (int i = 0; i < 4; i++) begin
            mode = modes[i];
            sweep2(golds[i], -1, dcyc);
            er = exp_resp(mode, rand_tt);
            checks++;
            if (dcyc != 16) begin
                errors++;
                $display("FAIL table%0d_done_cycle: got %0d expected 16", i, dcyc);
            end
            checks++;
            if (bus2.resp_vec !== er) begin
                errors++;
                $display("FAIL table%0d_resp: got %h expected %h", i, bus2.resp_vec, er);
            end
            checks++;
            if (bus2.signature !== exp_sig(er)) begin
                errors++;
                $display("FAIL table%0d_sig: got %h expected %h", i, bus2.signature, exp_sig(er));
            end
            checks++;
            if (bus2.mismatch_cnt !== 4'(popcnt(er ^ golds[i])) ||
                bus2.trojan_flag !== (popcnt(er ^ golds[i]) != 0)) begin
                errors++;
                $display("FAIL table%0d_mismatch: got cnt=%0d flag=%b expected cnt=%0d",
                         i, bus2.mismatch_cnt, bus2.trojan_flag, popcnt(er ^ golds[i]));
            end
        end
    endtask

    task automatic test_random();
        int dcyc;
        logic [7:0] er, g;
        mode = 4;
        for (int i = 0; i < 5; i++) begin
            rand_tt = 8'($urandom);
            g = (i == 0) ? rand_tt : 8'($urandom);
            sweep2(g, -1, dcyc);
            er = exp_resp(mode, rand_tt);
            checks++;
            if (dcyc != 16 || bus2.resp_vec !== er || bus2.signature !== exp_sig(er)) begin
                errors++;
                $display("FAIL rand%0d_capture: dcyc=%0d resp=%h sig=%h expected 16 %h %h",
                         i, dcyc, bus2.resp_vec, bus2.signature, er, exp_sig(er));
            end
            checks++;
            if (bus2.mismatch_cnt !== 4'(popcnt(er ^ g)) ||
                bus2.trojan_flag !== (er != g)) begin
                errors++;
                $display("FAIL rand%0d_mismatch: got cnt=%0d flag=%b expected cnt=%0d",
                         i, bus2.mismatch_cnt, bus2.trojan_flag, popcnt(er ^ g));
            end
        end
    endtask

    task automatic test_settle();
        logic [7:0] er;
        int e1, e3;
        mode = 4;
        rand_tt = 8'($urandom);
        er = exp_resp(mode, rand_tt);
        @(negedge CK);
        bus1.start = 1'b1; bus1.golden = er;
        bus3.start = 1'b1; bus3.golden = er;
        for (int c = 0; c <= 25; c++) begin
            @(posedge CK);
            #1;
            bus1.start = 1'b0;
            bus3.start = 1'b0;
            e1 = (c < 8) ? c : 7;
            e3 = (c < 24) ? c / 3 : 7;
            checks++;
            if (bus1.pattern !== 3'(e1) || bus1.pat_valid !== (c < 8) || bus1.done !== (c >= 8)) begin
                errors++;
                $display("FAIL settle1_c%0d: pat=%0d pv=%b done=%b expected %0d %b %b",
                         c, bus1.pattern, bus1.pat_valid, bus1.done, e1, c < 8, c >= 8);
            end
            checks++;
            if (bus3.pattern !== 3'(e3) || bus3.pat_valid !== (c < 24) || bus3.done !== (c >= 24)) begin
                errors++;
                $display("FAIL settle3_c%0d: pat=%0d pv=%b done=%b expected %0d %b %b",
                         c, bus3.pattern, bus3.pat_valid, bus3.done, e3, c < 24, c >= 24);
            end
        end
        checks++;
        if (bus1.resp_vec !== er || bus3.resp_vec !== er || bus1.trojan_flag !== 1'b0 ||
            bus3.trojan_flag !== 1'b0) begin
            errors++;
            $display("FAIL settle_resp: s1=%h s3=%h expected %h", bus1.resp_vec, bus3.resp_vec, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [34:0] obs;
        bit seen;
        int dcyc;
        mode = 2;
        @(negedge CK);
        bus2.start = 1'b1; bus2.golden = 8'h80;
        @(posedge CK);
        #1;
        bus2.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (bus2.pattern == 3'd4) seen = 1;
            else begin @(posedge CK); #1; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_reach4: pattern=%0d expected 4", bus2.pattern);
        end
        #2 reset = 1'b0;
        #1;
        obs = {bus2.pattern, bus2.pat_valid, bus2.busy, bus2.done, bus2.resp_vec,
               bus2.signature, bus2.mismatch_cnt, bus2.trojan_flag};
        checks++;
        if (obs !== {3'd0, 3'b000, 8'h00, 16'hFFFF, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_state: got %h expected %h", obs,
                     {3'd0, 3'b000, 8'h00, 16'hFFFF, 4'd0, 1'b0});
        end
        @(negedge CK);
        reset = 1'b1;
        mode = 3;
        sweep2(8'h80, -1, dcyc);
        checks++;
        if (dcyc != 16 || bus2.resp_vec !== 8'hA0 || bus2.mismatch_cnt !== 4'd1 ||
            bus2.trojan_flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_resweep: dcyc=%0d resp=%h cnt=%0d flag=%b expected 16 a0 1 1",
                     dcyc, bus2.resp_vec, bus2.mismatch_cnt, bus2.trojan_flag);
        end
    endtask

    task automatic test_start_in_apply();
        int dcyc;
        logic [7:0] er;
        mode = 4;
        rand_tt = 8'($urandom);
        er = exp_resp(mode, rand_tt);
        sweep2(er, 5, dcyc);
        checks++;
        if (dcyc != 16 || bus2.resp_vec !== er || bus2.signature !== exp_sig(er) ||
            bus2.trojan_flag !== 1'b0) begin
            errors++;
            $display("FAIL start_in_apply: dcyc=%0d resp=%h sig=%h flag=%b expected 16 %h %h 0",
                     dcyc, bus2.resp_vec, bus2.signature, bus2.trojan_flag, er, exp_sig(er));
        end
    endtask

    task automatic test_restart_done();
        logic [34:0] obs;
        logic [7:0] er, g;
        int dcyc;
        er = exp_resp(mode, rand_tt);
        g  = er ^ 8'h41;
        @(negedge CK);
        bus2.start = 1'b1; bus2.golden = g;
        @(posedge CK);
        #1;
        bus2.start = 1'b0; bus2.golden = 8'h00;
        obs = {bus2.pattern, bus2.pat_valid, bus2.busy, bus2.done, bus2.resp_vec,
               bus2.signature, bus2.mismatch_cnt, bus2.trojan_flag};
        checks++;
        if (obs !== {3'd0, 3'b110, 8'h00, 16'hFFFF, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_clear: got %h expected %h", obs,
                     {3'd0, 3'b110, 8'h00, 16'hFFFF, 4'd0, 1'b0});
        end
        dcyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge CK);
            #1;
            if (bus2.done) begin dcyc = c; break; end
        end
        checks++;
        if (dcyc != 16 || bus2.resp_vec !== er || bus2.mismatch_cnt !== 4'd2 ||
            bus2.trojan_flag !== 1'b1) begin
            errors++;
            $display("FAIL restart_result: dcyc=%0d resp=%h cnt=%0d flag=%b expected 16 %h 2 1",
                     dcyc, bus2.resp_vec, bus2.mismatch_cnt, bus2.trojan_flag, er);
        end
    endtask

    initial begin
        test_reset();
        test_sweep_table();
        test_random();
        test_settle();
        test_reset_mid();
        test_start_in_apply();
        test_restart_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
